// File: rtl/rr_mux_pkg.sv
// Package shared by the rr_mux_nx1 slice.
// Contents:
//   clog2_min1(n) - index width for n channels, never less than 1 bit
//   ptr_rst(n)    - reset value of the round-robin pointer (n-1), so that
//                   channel 0 is searched first after reset
//   chan_idx_t    - channel index type for the default 4-channel build
//   PTR_RST       - pointer reset pattern for the default build
package rr_mux_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_rst(input int n);
    return n - 1;
  endfunction

  localparam int N_DEFAULT  = 4;
  localparam int CW_DEFAULT = clog2_min1(N_DEFAULT);

  typedef logic [CW_DEFAULT-1:0] chan_idx_t;

  localparam chan_idx_t PTR_RST = chan_idx_t'(ptr_rst(N_DEFAULT));

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter.
// Ports:
//   req  in  N   request vector (one bit per channel)
//   ptr  in  CW  last granted channel; search starts at ptr+1 with wrap
//   en   in  1   grant enable; gnt is zero when en=0
//   gnt  out N   one-hot grant, or zero when nothing is requested
// Configuration macro RR_MUX_FIXED_PRIO_EN: when defined, the lowest
// requesting index always wins and ptr is ignored.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_min1(N)-1:0]   ptr,
  input  logic                       en,
  output logic [N-1:0]               gnt
);

  logic found;

`ifdef RR_MUX_FIXED_PRIO_EN
  // Pointer has no meaning in fixed-priority mode.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
`else
  int idx;

  // Walk the channels starting just after the last winner, wrapping
  // around, and take the first requester encountered.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rr_mux_nx1.sv
// N-to-1 channel selector with round-robin arbitration and a one-entry
// registered output buffer.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-high reset
//   in_data    in   N*W   channel i data at [i*W +: W]
//   in_valid   in   N     channel i offers a beat
//   in_ready   out  N     channel i beat accepted this cycle (one-hot/zero)
//   out_data   out  W     buffered beat
//   out_chan   out  CW    source channel of out_data
//   out_valid  out  1     buffer holds a beat
//   out_ready  in   1     consumer takes the beat
// Configuration macro RR_MUX_FIXED_PRIO_EN: fixed lowest-index priority
// instead of round robin; the pointer then stays at its reset value.
module rr_mux_nx1
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int CW = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CW-1:0] PTR_RST_VAL = CW'(ptr_rst(N));

  logic [W-1:0]  out_data_reg;
  logic [CW-1:0] out_chan_reg;
  logic          out_valid_reg;
  logic [CW-1:0] ptr_reg;

  logic          load;
  logic          arb_en;
  logic          xfer;
  logic [N-1:0]  gnt;
  logic [CW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic [W-1:0]  slice [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign slice[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // The buffer can take a new beat when empty or when it is being drained
  // in this same cycle, which gives full throughput without bubbles.
  assign load   = !out_valid_reg || out_ready;
  assign arb_en = load && !rst;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req (in_valid),
    .ptr (ptr_reg),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign in_ready = gnt & {N{arb_en}};
  assign xfer     = |(in_valid & in_ready);

  // Encode the one-hot grant and pick the matching data slice.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = CW'(i);
        gnt_data = slice[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= PTR_RST_VAL;
    end else if (xfer) begin
      out_data_reg  <= gnt_data;
      out_chan_reg  <= gnt_idx;
      out_valid_reg <= 1'b1;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr_reg       <= gnt_idx;
`endif
    end else if (out_ready) begin
      // Drained with nothing to refill; data/chan keep their old values.
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

endmodule
